// File: rtl/jt10_adpcmb_fetch_if.sv
// ROM-side read handshake of the ADPCM-B fetcher: address plus cs held until ok.
// The fetcher drives the master modport and the ROM controller drives the slave modport.
interface jt10_adpcmb_fetch_if #(
  parameter int unsigned AW = 24
);
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (
    output rom_addr,
    output rom_cs,
    input  rom_data,
    input  rom_ok
  );

  modport slave (
    input  rom_addr,
    input  rom_cs,
    output rom_data,
    output rom_ok
  );
endinterface

// File: rtl/jt10_adpcmb_fetch.sv
// ADPCM-B sample fetcher: two byte buffers (current and prefetched) filled over a cs/ok ROM
// handshake, delivering one 4-bit ADPCM code per cen-qualified advance strobe.
module jt10_adpcmb_fetch #(
  parameter int unsigned AW       = 24,
  parameter bit          PREFETCH = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                on,
  input  logic [AW-1:0]       addr,
  input  logic                nibble_sel,
  input  logic                adv,
  jt10_adpcmb_fetch_if.master rom,
  output logic [3:0]          data,
  output logic                data_ok,
  output logic                miss,
  input  logic                clr_miss
);

  typedef enum logic [1:0] {StIdle, StFcur, StFnxt} state_e;

  state_e        state_q;
  logic [AW-1:0] rom_addr_q;
  logic          rom_cs_q;
  logic [AW-1:0] cur_addr_q, nxt_addr_q;
  logic [7:0]    cur_byte_q, nxt_byte_q;
  logic          cur_vld_q, nxt_vld_q;

  logic          cur_hit, nxt_hit, land_is_addr;
  logic [AW-1:0] cur_inc;

  assign rom.rom_addr = rom_addr_q;
  assign rom.rom_cs   = rom_cs_q;

  assign cur_hit      = cur_vld_q && (cur_addr_q == addr);
  assign nxt_hit      = nxt_vld_q && (nxt_addr_q == addr);
  assign land_is_addr = (rom_addr_q == addr);
  assign cur_inc      = cur_addr_q + {{(AW-1){1'b0}}, 1'b1};

  // Fetch FSM and buffer maintenance. Buffer flush/promotion is written first so a landing
  // byte in the same clk overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
      cur_addr_q <= '0;
      nxt_addr_q <= '0;
      cur_byte_q <= '0;
      nxt_byte_q <= '0;
      cur_vld_q  <= 1'b0;
      nxt_vld_q  <= 1'b0;
    end else begin
      if (!on) begin
        cur_vld_q <= 1'b0;
        nxt_vld_q <= 1'b0;
      end else if (!cur_hit) begin
        if (nxt_hit) begin
          cur_addr_q <= nxt_addr_q;
          cur_byte_q <= nxt_byte_q;
          cur_vld_q  <= 1'b1;
          nxt_vld_q  <= 1'b0;
        end else begin
          cur_vld_q  <= 1'b0;
          nxt_vld_q  <= 1'b0;
        end
      end

      unique case (state_q)
        StIdle: begin
          // While a promotion is in flight, wait one clk before prefetching past it.
          if (on && !cur_hit && !nxt_hit) begin
            rom_addr_q <= addr;
            rom_cs_q   <= 1'b1;
            state_q    <= StFcur;
          end else if (PREFETCH && on && cur_hit && !nxt_vld_q) begin
            rom_addr_q <= cur_inc;
            rom_cs_q   <= 1'b1;
            state_q    <= StFnxt;
          end
        end
        StFcur: begin
          if (rom.rom_ok) begin
            rom_cs_q <= 1'b0;
            state_q  <= StIdle;
            if (on && land_is_addr) begin
              cur_addr_q <= rom_addr_q;
              cur_byte_q <= rom.rom_data;
              cur_vld_q  <= 1'b1;
            end
          end
        end
        StFnxt: begin
          if (rom.rom_ok) begin
            rom_cs_q <= 1'b0;
            state_q  <= StIdle;
            if (on && land_is_addr) begin
              cur_addr_q <= rom_addr_q;
              cur_byte_q <= rom.rom_data;
              cur_vld_q  <= 1'b1;
            end else if (on && cur_hit) begin
              nxt_addr_q <= rom_addr_q;
              nxt_byte_q <= rom.rom_data;
              nxt_vld_q  <= 1'b1;
            end
          end
        end
        default: begin
          rom_cs_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  // Decoder-side sample register, updated only on cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= 4'd0;
      data_ok <= 1'b0;
      miss    <= 1'b0;
    end else begin
      if (cen) begin
        if (!on) begin
          data    <= 4'd0;
          data_ok <= 1'b0;
        end else if (adv) begin
          if (cur_hit) begin
            data    <= nibble_sel ? cur_byte_q[3:0] : cur_byte_q[7:4];
            data_ok <= 1'b1;
          end else begin
            data_ok <= 1'b0;
          end
        end
      end

      if (cen && on && adv && !cur_hit) begin
        miss <= 1'b1;
      end else if (clr_miss) begin
        miss <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jt10_adpcmb_fetch.sv
// Self-checking bench for jt10_adpcmb_fetch: ROM responder with fixed latency, request monitor,
// and per-scenario tasks checking decoder output and ROM request sequence against scoreboards.
module tb_jt10_adpcmb_fetch;

  localparam int unsigned AW = 24;
  localparam int RomLat = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen, on, nibble_sel, adv, clr_miss;
  logic [AW-1:0] addr;
  logic [3:0]    data;
  logic          data_ok, miss;

  jt10_adpcmb_fetch_if #(.AW(AW)) rom_bus ();

  jt10_adpcmb_fetch #(.AW(AW), .PREFETCH(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .on         (on),
    .addr       (addr),
    .nibble_sel (nibble_sel),
    .adv        (adv),
    .rom        (rom_bus.master),
    .data       (data),
    .data_ok    (data_ok),
    .miss       (miss),
    .clr_miss   (clr_miss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_req[$];
  logic [AW-1:0] obs_req[$];
  logic [4:0]    exp_out[$];
  logic [4:0]    exp_o;
  logic [AW-1:0] ra, rb;
  logic [3:0]    last_data;

  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA4;
  endfunction

  // ROM controller model: ok rises RomLat clks after cs is seen, for one clk.
  int rom_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_bus.rom_ok   <= 1'b0;
      rom_bus.rom_data <= 8'd0;
      rom_cnt          <= 0;
    end else if (!rom_bus.rom_cs || rom_bus.rom_ok) begin
      rom_bus.rom_ok <= 1'b0;
      rom_cnt        <= 0;
    end else if (rom_cnt == RomLat - 1) begin
      rom_bus.rom_ok   <= 1'b1;
      rom_bus.rom_data <= rom_byte(rom_bus.rom_addr);
    end else begin
      rom_cnt <= rom_cnt + 1;
    end
  end

  logic cs_seen = 1'b0;
  always @(negedge clk) begin
    if (rom_bus.rom_cs && !cs_seen) obs_req.push_back(rom_bus.rom_addr);
    cs_seen = rom_bus.rom_cs;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cen_pulse(input logic a, input logic nib);
    cen = 1'b1;
    adv = a;
    nibble_sel = nib;
    tick(1);
    cen = 1'b0;
    adv = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (rom_bus.rom_cs !== 1'b0) begin
      errors++; $display("FAIL reset_cs: got %b want 0", rom_bus.rom_cs);
    end
    checks++;
    if (rom_bus.rom_addr !== '0) begin
      errors++; $display("FAIL reset_addr: got %h want 0", rom_bus.rom_addr);
    end
    checks++;
    if ({data_ok, data} !== 5'd0) begin
      errors++; $display("FAIL reset_data: got %b/%h want 0/0", data_ok, data);
    end
    checks++;
    if (miss !== 1'b0) begin
      errors++; $display("FAIL reset_miss: got %b want 0", miss);
    end
  endtask

  task automatic test_fetch;
    on = 1'b1;
    addr = 24'h000100;
    exp_req.push_back(24'h000100);
    exp_req.push_back(24'h000101);
    tick(20);
    ra = 24'h000100;
    exp_out.push_back({1'b1, rom_byte(ra)[7:4]});
    cen_pulse(1'b1, 1'b0);
    exp_o = exp_out.pop_front();
    checks++;
    if ({data_ok, data} !== exp_o) begin
      errors++; $display("FAIL fetch_hi: got %h want %h", {data_ok, data}, exp_o);
    end
    exp_out.push_back({1'b1, rom_byte(ra)[3:0]});
    cen_pulse(1'b1, 1'b1);
    exp_o = exp_out.pop_front();
    checks++;
    if ({data_ok, data} !== exp_o) begin
      errors++; $display("FAIL fetch_lo: got %h want %h", {data_ok, data}, exp_o);
    end
    checks++;
    if (miss !== 1'b0) begin
      errors++; $display("FAIL fetch_miss: got %b want 0", miss);
    end
    checks++;
    if (obs_req.size() != exp_req.size()) begin
      errors++; $display("FAIL fetch_nreq: got %0d want %0d", obs_req.size(), exp_req.size());
    end
    while (obs_req.size() > 0 && exp_req.size() > 0) begin
      ra = obs_req.pop_front();
      rb = exp_req.pop_front();
      checks++;
      if (ra !== rb) begin
        errors++; $display("FAIL fetch_req: got %h want %h", ra, rb);
      end
    end
    obs_req.delete();
    exp_req.delete();
    last_data = 4'h5;
  endtask

  task automatic test_prefetch;
    addr = 24'h000101;
    exp_req.push_back(24'h000102);
    tick(2);
    ra = 24'h000101;
    exp_out.push_back({1'b1, rom_byte(ra)[7:4]});
    cen_pulse(1'b1, 1'b0);
    exp_o = exp_out.pop_front();
    checks++;
    if ({data_ok, data} !== exp_o) begin
      errors++; $display("FAIL prefetch_hit: got %h want %h", {data_ok, data}, exp_o);
    end
    last_data = exp_o[3:0];
    tick(15);
    checks++;
    if (miss !== 1'b0) begin
      errors++; $display("FAIL prefetch_miss: got %b want 0", miss);
    end
    checks++;
    if (obs_req.size() != exp_req.size()) begin
      errors++; $display("FAIL prefetch_nreq: got %0d want %0d", obs_req.size(), exp_req.size());
    end
    while (obs_req.size() > 0 && exp_req.size() > 0) begin
      ra = obs_req.pop_front();
      rb = exp_req.pop_front();
      checks++;
      if (ra !== rb) begin
        errors++; $display("FAIL prefetch_req: got %h want %h", ra, rb);
      end
    end
    obs_req.delete();
    exp_req.delete();
  endtask

  task automatic test_jump;
    addr = 24'h004000;
    exp_req.push_back(24'h004000);
    exp_req.push_back(24'h004001);
    tick(1);
    checks++;
    if (rom_bus.rom_cs !== 1'b1 || rom_bus.rom_addr !== 24'h004000) begin
      errors++;
      $display("FAIL jump_req: got cs=%b addr=%h want cs=1 addr=004000",
               rom_bus.rom_cs, rom_bus.rom_addr);
    end
    exp_out.push_back({1'b0, last_data});
    cen_pulse(1'b1, 1'b0);
    exp_o = exp_out.pop_front();
    checks++;
    if ({data_ok, data} !== exp_o || miss !== 1'b1) begin
      errors++;
      $display("FAIL jump_underrun: got %h miss=%b want %h miss=1", {data_ok, data}, miss, exp_o);
    end
    clr_miss = 1'b1;
    tick(1);
    clr_miss = 1'b0;
    tick(15);
    checks++;
    if (miss !== 1'b0) begin
      errors++; $display("FAIL jump_clr: got %b want 0", miss);
    end
    ra = 24'h004000;
    exp_out.push_back({1'b1, rom_byte(ra)[3:0]});
    cen_pulse(1'b1, 1'b1);
    exp_o = exp_out.pop_front();
    checks++;
    if ({data_ok, data} !== exp_o) begin
      errors++; $display("FAIL jump_hit: got %h want %h", {data_ok, data}, exp_o);
    end
    checks++;
    if (obs_req.size() != exp_req.size()) begin
      errors++; $display("FAIL jump_nreq: got %0d want %0d", obs_req.size(), exp_req.size());
    end
    while (obs_req.size() > 0 && exp_req.size() > 0) begin
      ra = obs_req.pop_front();
      rb = exp_req.pop_front();
      checks++;
      if (ra !== rb) begin
        errors++; $display("FAIL jump_reqaddr: got %h want %h", ra, rb);
      end
    end
    obs_req.delete();
    exp_req.delete();
  endtask

  task automatic test_on_drop;
    addr = 24'h000200;
    exp_req.push_back(24'h000200);
    exp_req.push_back(24'h000200);
    exp_req.push_back(24'h000201);
    tick(1);
    on = 1'b0;
    tick(2);
    checks++;
    if (rom_bus.rom_cs !== 1'b1) begin
      errors++; $display("FAIL drop_hold: got cs=%b want 1", rom_bus.rom_cs);
    end
    for (int i = 0; i < 20 && rom_bus.rom_cs; i++) tick(1);
    checks++;
    if (rom_bus.rom_cs !== 1'b0) begin
      errors++; $display("FAIL drop_timeout: got cs=%b want 0", rom_bus.rom_cs);
    end
    exp_out.push_back(5'd0);
    cen_pulse(1'b1, 1'b0);
    exp_o = exp_out.pop_front();
    checks++;
    if ({data_ok, data} !== exp_o || miss !== 1'b0) begin
      errors++;
      $display("FAIL drop_out: got %h miss=%b want %h miss=0", {data_ok, data}, miss, exp_o);
    end
    on = 1'b1;
    tick(20);
    ra = 24'h000200;
    exp_out.push_back({1'b1, rom_byte(ra)[7:4]});
    cen_pulse(1'b1, 1'b0);
    exp_o = exp_out.pop_front();
    checks++;
    if ({data_ok, data} !== exp_o) begin
      errors++; $display("FAIL drop_refetch: got %h want %h", {data_ok, data}, exp_o);
    end
    checks++;
    if (obs_req.size() != exp_req.size()) begin
      errors++; $display("FAIL drop_nreq: got %0d want %0d", obs_req.size(), exp_req.size());
    end
    while (obs_req.size() > 0 && exp_req.size() > 0) begin
      ra = obs_req.pop_front();
      rb = exp_req.pop_front();
      checks++;
      if (ra !== rb) begin
        errors++; $display("FAIL drop_req: got %h want %h", ra, rb);
      end
    end
    obs_req.delete();
    exp_req.delete();
  endtask

  task automatic test_wrap;
    addr = 24'hFFFFFF;
    exp_req.push_back(24'hFFFFFF);
    exp_req.push_back(24'h000000);
    tick(20);
    ra = 24'hFFFFFF;
    exp_out.push_back({1'b1, rom_byte(ra)[3:0]});
    cen_pulse(1'b1, 1'b1);
    exp_o = exp_out.pop_front();
    checks++;
    if ({data_ok, data} !== exp_o) begin
      errors++; $display("FAIL wrap_data: got %h want %h", {data_ok, data}, exp_o);
    end
    checks++;
    if (obs_req.size() != exp_req.size()) begin
      errors++; $display("FAIL wrap_nreq: got %0d want %0d", obs_req.size(), exp_req.size());
    end
    while (obs_req.size() > 0 && exp_req.size() > 0) begin
      ra = obs_req.pop_front();
      rb = exp_req.pop_front();
      checks++;
      if (ra !== rb) begin
        errors++; $display("FAIL wrap_req: got %h want %h", ra, rb);
      end
    end
    obs_req.delete();
    exp_req.delete();
  endtask

  task automatic test_miss_clr;
    addr = 24'h000300;
    exp_req.push_back(24'h000300);
    exp_req.push_back(24'h000301);
    clr_miss = 1'b1;
    cen = 1'b1;
    adv = 1'b1;
    tick(1);
    cen = 1'b0;
    adv = 1'b0;
    checks++;
    if (miss !== 1'b1 || data_ok !== 1'b0) begin
      errors++; $display("FAIL miss_prio: got miss=%b ok=%b want miss=1 ok=0", miss, data_ok);
    end
    tick(1);
    clr_miss = 1'b0;
    checks++;
    if (miss !== 1'b0) begin
      errors++; $display("FAIL miss_clear: got %b want 0", miss);
    end
    tick(20);
    checks++;
    if (obs_req.size() != exp_req.size()) begin
      errors++; $display("FAIL miss_nreq: got %0d want %0d", obs_req.size(), exp_req.size());
    end
    while (obs_req.size() > 0 && exp_req.size() > 0) begin
      ra = obs_req.pop_front();
      rb = exp_req.pop_front();
      checks++;
      if (ra !== rb) begin
        errors++; $display("FAIL miss_req: got %h want %h", ra, rb);
      end
    end
    obs_req.delete();
    exp_req.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    cen = 1'b0;
    on = 1'b0;
    addr = '0;
    nibble_sel = 1'b0;
    adv = 1'b0;
    clr_miss = 1'b0;
    last_data = 4'h0;
    tick(3);
    test_reset();
    rst_n = 1'b1;
    tick(1);
    test_fetch();
    test_prefetch();
    test_jump();
    test_on_drop();
    test_wrap();
    test_miss_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
